apb_master_bridge_mc: RTL and testbench
=======================================

Name: apb_master_bridge_mc

Overview:
Parametrised next-generation APB master bridge. Accepts single read/write requests from an internal valid/ready request port and runs a full APB SETUP/ACCESS transfer to one of NUM_SLAVES peripherals. The target peripheral is selected by decoding the high address bits. Adds capabilities the current bridge lacks: per-slave PSEL, byte strobes, PSLVERR capture, a wait-state timeout, and a registered response pulse carrying read data and status.

Parameters:
ADDR_WIDTH, 16, width of paddr and req_addr
DATA_WIDTH, 16, width of data buses; must be a multiple of 8
NUM_SLAVES, 4, number of APB slaves; SEL_W = clog2(NUM_SLAVES)
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
pclk  in  1  peripheral clock; all logic is on the rising edge
preset  in  1  reset, synchronous and active-high
req_valid  in  1  request present
req_ready  out  1  bridge can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_strb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  slave error, decode error or timeout
rsp_timeout  out  1  the error was a timeout
psel  out  NUM_SLAVES  one-hot slave select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes; forced to 0 on reads
pready  in  NUM_SLAVES  per-slave ready
prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (preset high at a rising edge):
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err and rsp_timeout all go to 0.
  - Any in-flight transfer is dropped and no response is produced.
- Request handshake:
  - req_ready = 1 only in IDLE and when preset is low.
  - A request is accepted at the rising edge where req_valid and req_ready are both 1.
  - Accepted fields are registered into paddr, pwdata, pwrite and pstrb; these hold stable through SETUP and ACCESS.
- Decode:
  - idx = req_addr[ADDR_WIDTH-1 -: SEL_W]; when NUM_SLAVES = 1, idx = 0.
  - If idx >= NUM_SLAVES, the request is a decode error: psel is never asserted, and the next cycle goes to IDLE with rsp_valid = 1, rsp_err = 1, rsp_timeout = 0.
- State IDLE: psel = 0, penable = 0. On acceptance with a valid decode, go to SETUP.
- State SETUP (exactly one cycle): psel[idx] = 1, penable = 0. Always go to ACCESS.
- State ACCESS: psel[idx] = 1, penable = 1. Sample pready[idx] at each rising edge.
  - pready[idx] = 1: the transfer completes. Go to IDLE; in the next cycle rsp_valid = 1 and rsp_err = pslverr[idx].
  - rsp_rdata = prdata slice idx for an error-free read; otherwise rsp_rdata = 0.
  - pready of non-selected slaves is ignored.
- Timeout:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready[idx] = 0.
  - If TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES, the transfer aborts: go to IDLE and drop psel/penable.
  - The abort response is rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If pready arrives on the same edge as the counter hits the limit, completion wins.
- Response timing:
  - rsp_valid is a single-cycle pulse in the IDLE cycle following completion. There is no backpressure.
  - rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
  - Minimum turnaround, accept to accept, is 3 cycles: SETUP, ACCESS, IDLE.
- Reset mid-transfer: the bus is released at that edge, and no rsp_valid is produced for the aborted transfer.

Decomposition:
- Package apb_pkg holds:
  - enum apb_state_t {IDLE, SETUP, ACCESS}
  - function clog2_min1 (returns 1 for an argument of 1)
  - a response struct {rdata, err, timeout}
- Sub-module apb_addr_decode (combinational): addr -> one-hot select, idx, decode_err. Everything else lives in the top.

Test Plan:
- Read from slave 1, zero wait (ADDR 16, NUM 4, addr 0x4010; slave 1 returns 0x00EE with pready=1) -> psel=0b0010 for 2 cycles, penable only in the second; rsp_valid one cycle later with rsp_rdata=0x00EE, rsp_err=0.
- Write 0xBEEF, strb=0b11, to addr 0xC004 with slave 3 holding pready low for 3 ACCESS cycles -> psel=0b1000 for 5 cycles; paddr/pwdata/pstrb stable throughout; rsp_err=0, rsp_rdata=0.
- Slave 0 completes a read with pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT_CYCLES=4, slave never ready -> penable high exactly 4 cycles, then psel=0; rsp_err=1, rsp_timeout=1; req_ready=1 in that same cycle.
- NUM_SLAVES=3, addr 0xC000 -> no psel asserted; rsp_valid 1 cycle after acceptance with rsp_err=1.
- preset asserted in the second ACCESS cycle -> all outputs 0 at the next edge; no rsp_valid; a new request is accepted normally after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM states, response record and a
// clog2 helper that never returns 0.
package apb_pkg;

  // Widest data bus the response record can carry.
  localparam int RSP_DATA_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  typedef struct packed {
    logic [RSP_DATA_MAX-1:0] rdata;
    logic                    err;
    logic                    timeout;
  } apb_rsp_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: high address bits -> slave index, one-hot select
// and a decode error when the index names a slave that does not exist.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  localparam int SEL_W = clog2_min1(NUM_SLAVES)
) (
  input  logic [SEL_W-1:0]      addr_hi,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [SEL_W-1:0]      idx,
  output logic                  decode_err
);

  localparam logic [SEL_W:0] NUM_L = (SEL_W + 1)'(NUM_SLAVES);

  assign idx        = (NUM_SLAVES == 1) ? '0 : addr_hi;
  assign decode_err = ({1'b0, idx} >= NUM_L);

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
    assign sel[gi] = !decode_err && (idx == SEL_W'(gi));
  end

endmodule

// File: rtl/apb_master_bridge_mc.sv
// APB master bridge: one valid/ready request at a time, driven as a full
// SETUP/ACCESS transfer to a decoded slave, with error and timeout reporting.
module apb_master_bridge_mc
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [DATA_WIDTH/8-1:0]          req_strb,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [DATA_WIDTH/8-1:0]          pstrb,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SEL_W  = clog2_min1(NUM_SLAVES);
  localparam int CNT_W  = clog2_min1(TIMEOUT_CYCLES + 1);
  // wait_reg holds the pready-low cycles already seen, so the limit is hit in
  // the ACCESS cycle where it equals TIMEOUT_CYCLES-1 and pready is still low.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_t              state_reg, state_next;
  logic [NUM_SLAVES-1:0]   sel_reg, dec_sel;
  logic [SEL_W-1:0]        idx_reg, dec_idx;
  logic                    dec_err;
  logic [CNT_W-1:0]        wait_reg, wait_next;
  apb_rsp_t                rsp_reg, rsp_next;
  logic                    rsp_valid_reg, rsp_fire;
  logic [ADDR_WIDTH-1:0]   paddr_reg;
  logic [DATA_WIDTH-1:0]   pwdata_reg, rdata_sel;
  logic [STRB_W-1:0]       pstrb_reg;
  logic                    pwrite_reg;
  logic                    accept, pready_sel, pslverr_sel, timeout_hit;
  logic                    unused_rsp_bits;

  apb_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES)
  ) u_decode (
    .addr_hi    (req_addr[ADDR_WIDTH-1 -: SEL_W]),
    .sel        (dec_sel),
    .idx        (dec_idx),
    .decode_err (dec_err)
  );

  assign req_ready   = (state_reg == IDLE) && !preset;
  assign accept      = req_valid && req_ready;
  assign pready_sel  = |(pready & sel_reg);
  assign pslverr_sel = |(pslverr & sel_reg);
  assign rdata_sel   = prdata[int'(idx_reg) * DATA_WIDTH +: DATA_WIDTH];
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    rsp_fire   = 1'b0;
    rsp_next   = rsp_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (dec_err) begin
            rsp_fire = 1'b1;
            rsp_next = '{rdata: '0, err: 1'b1, timeout: 1'b0};
          end else begin
            state_next = SETUP;
          end
        end
      end
      SETUP: begin
        state_next = ACCESS;
        wait_next  = '0;
      end
      ACCESS: begin
        // Completion is checked first so a late pready beats the timeout.
        if (pready_sel) begin
          state_next       = IDLE;
          rsp_fire         = 1'b1;
          rsp_next.rdata   = (!pwrite_reg && !pslverr_sel) ? RSP_DATA_MAX'(rdata_sel) : '0;
          rsp_next.err     = pslverr_sel;
          rsp_next.timeout = 1'b0;
        end else if (timeout_hit) begin
          state_next = IDLE;
          rsp_fire   = 1'b1;
          rsp_next   = '{rdata: '0, err: 1'b1, timeout: 1'b1};
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_reg       <= '0;
      sel_reg       <= '0;
      idx_reg       <= '0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pstrb_reg     <= '0;
      pwrite_reg    <= 1'b0;
    end else begin
      wait_reg      <= wait_next;
      rsp_valid_reg <= rsp_fire;
      if (rsp_fire) begin
        rsp_reg <= rsp_next;
      end
      if (accept) begin
        sel_reg    <= dec_sel;
        idx_reg    <= dec_idx;
        paddr_reg  <= req_addr;
        pwdata_reg <= req_wdata;
        pstrb_reg  <= req_write ? req_strb : '0;
        pwrite_reg <= req_write;
      end
    end
  end

  assign psel        = (state_reg == IDLE) ? '0 : sel_reg;
  assign penable     = (state_reg == ACCESS);
  assign pwrite      = pwrite_reg;
  assign paddr       = paddr_reg;
  assign pwdata      = pwdata_reg;
  assign pstrb       = pstrb_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_reg.rdata[DATA_WIDTH-1:0];
  assign rsp_err     = rsp_reg.err;
  assign rsp_timeout = rsp_reg.timeout;

  // Response record is sized for the widest bus; the spare rdata bits are dead.
  assign unused_rsp_bits = ^rsp_reg.rdata;

endmodule

// File: tb/tb_apb_master_bridge_mc.sv
// Scoreboard bench for apb_master_bridge_mc: a driver pushes expected responses,
// a monitor pops them on rsp_valid, and a slave model answers on the APB side.
module tb_apb_master_bridge_mc;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int NS  = 3;
  localparam int TO  = 5;
  localparam int SW  = 2;
  localparam int STW = DW / 8;

  logic              pclk = 1'b0;
  logic              preset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic [STW-1:0]    req_strb = '0;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [NS-1:0]     psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [STW-1:0]    pstrb;
  logic [NS-1:0]     pready = '0;
  logic [NS*DW-1:0]  prdata = '0;
  logic [NS-1:0]     pslverr = '0;

  apb_master_bridge_mc #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Current transfer as the slave model and bus checker should see it.
  int             scen_idx = 0;
  int             scen_w = 0;
  logic           scen_err = 1'b0;
  logic [DW-1:0]  scen_rdata = '0;
  logic [NS-1:0]  exp_psel = '0;
  logic [AW-1:0]  exp_paddr = '0;
  logic [DW-1:0]  exp_pwdata = '0;
  logic [STW-1:0] exp_pstrb = '0;
  logic           exp_pwrite = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  // Slave model: selected slave raises pready in ACCESS cycle scen_w+1; the
  // other slaves babble random ready/error/data that must be ignored.
  initial begin
    int acc_n;
    acc_n = 0;
    forever begin
      @(negedge pclk);
      if (psel != '0 && penable) acc_n = acc_n + 1;
      else acc_n = 0;
      for (int i = 0; i < NS; i++) begin
        pready[i]            = 1'($urandom);
        pslverr[i]           = 1'($urandom);
        prdata[i*DW +: DW]   = DW'($urandom);
      end
      if (psel != '0 && scen_idx < NS) begin
        pready[scen_idx]          = penable && (acc_n == scen_w + 1);
        pslverr[scen_idx]         = scen_err;
        prdata[scen_idx*DW +: DW] = scen_rdata;
      end
    end
  end

  // Monitor: pops on every response, checks held values between responses
  // and checks the APB bus fields while a slave is selected.
  initial begin
    exp_t          e;
    logic [DW-1:0] last_rd;
    logic          last_err;
    logic          last_tmo;
    last_rd = '0; last_err = 1'b0; last_tmo = 1'b0;
    forever begin
      @(negedge pclk);
      if (preset) begin
        last_rd = '0; last_err = 1'b0; last_tmo = 1'b0;
      end else if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp cyc=%0d got rdata=%h err=%b tmo=%b, none expected",
                   cyc, rsp_rdata, rsp_err, rsp_timeout);
        end else begin
          e = exp_q.pop_front();
          if (rsp_rdata !== e.rdata || rsp_err !== e.err || rsp_timeout !== e.tmo || cyc != e.cyc) begin
            failures++;
            $display("FAIL rsp got rdata=%h err=%b tmo=%b cyc=%0d, want rdata=%h err=%b tmo=%b cyc=%0d",
                     rsp_rdata, rsp_err, rsp_timeout, cyc, e.rdata, e.err, e.tmo, e.cyc);
          end
          last_rd = e.rdata; last_err = e.err; last_tmo = e.tmo;
        end
      end else begin
        checks++;
        if (rsp_rdata !== last_rd || rsp_err !== last_err || rsp_timeout !== last_tmo) begin
          failures++;
          $display("FAIL rsp_hold cyc=%0d got rdata=%h err=%b tmo=%b, want rdata=%h err=%b tmo=%b",
                   cyc, rsp_rdata, rsp_err, rsp_timeout, last_rd, last_err, last_tmo);
        end
      end
      if (!preset && psel != '0) begin
        checks++;
        if (psel !== exp_psel || paddr !== exp_paddr || pwdata !== exp_pwdata ||
            pstrb !== exp_pstrb || pwrite !== exp_pwrite) begin
          failures++;
          $display("FAIL bus cyc=%0d got psel=%b paddr=%h pwdata=%h pstrb=%b pwrite=%b, want psel=%b paddr=%h pwdata=%h pstrb=%b pwrite=%b",
                   cyc, psel, paddr, pwdata, pstrb, pwrite,
                   exp_psel, exp_paddr, exp_pwdata, exp_pstrb, exp_pwrite);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if (psel !== '0 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0 ||
        pstrb !== '0 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 ||
        rsp_timeout !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%b rv=%b rd=%h err=%b tmo=%b rdy=%b, want all 0",
               name, psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata,
               rsp_err, rsp_timeout, req_ready);
    end
  endtask

  // Issue one request at a negedge in IDLE; expected result follows the
  // decode / timeout / completion rules with the slave's wait count w.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [STW-1:0] strb, input int w, input logic er,
                         input logic [DW-1:0] rd, input bit abort);
    int   idx;
    int   guard;
    exp_t e;
    idx        = int'(addr[AW-1 -: SW]);
    scen_idx   = idx;
    scen_w     = w;
    scen_err   = er;
    scen_rdata = rd;
    exp_psel   = '0;
    if (idx < NS) exp_psel[idx] = 1'b1;
    exp_paddr  = addr;
    exp_pwdata = wd;
    exp_pstrb  = wr ? strb : '0;
    exp_pwrite = wr;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_strb = strb;
    @(posedge pclk);
    #1;
    if (idx >= NS) begin
      e = '{rdata: '0, err: 1'b1, tmo: 1'b0, cyc: cyc};
    end else if (w >= TO) begin
      e = '{rdata: '0, err: 1'b1, tmo: 1'b1, cyc: cyc + TO + 1};
    end else begin
      e = '{rdata: (!wr && !er) ? rd : '0, err: er, tmo: 1'b0, cyc: cyc + w + 2};
    end
    if (!abort) exp_q.push_back(e);
    @(negedge pclk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
    req_strb = STW'($urandom);
    if (abort) begin
      @(negedge pclk);
      @(negedge pclk);
      preset = 1'b1;
      @(negedge pclk);
      check_reset_outputs("mid_reset");
      preset = 1'b0;
    end
    guard = 0;
    while (req_ready !== 1'b1 && guard < 40) begin
      @(negedge pclk);
      guard++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_return got req_ready=%b after %0d cycles, want 1", req_ready, guard);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge pclk);
    check_reset_outputs("reset_state");
    preset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %b want 1", req_ready);
    end
    @(negedge pclk);

    run_txn(1'b0, 16'h4010, 16'h1234, 2'b11, 0, 1'b0, 16'h00EE, 1'b0);  // slave 1 read, no wait
    run_txn(1'b1, 16'h8004, 16'hBEEF, 2'b11, 3, 1'b0, 16'h5555, 1'b0);  // slave 2 write, 3 waits
    run_txn(1'b0, 16'h0020, 16'h0000, 2'b01, 1, 1'b1, 16'hABCD, 1'b0);  // slave 0 read error
    run_txn(1'b0, 16'h0008, 16'h0000, 2'b00, 100, 1'b0, 16'h1111, 1'b0); // never ready
    run_txn(1'b0, 16'h4000, 16'h0000, 2'b00, TO - 1, 1'b0, 16'h7777, 1'b0); // ready on limit edge
    run_txn(1'b1, 16'h8000, 16'h2222, 2'b10, TO, 1'b0, 16'h7777, 1'b0);  // one past limit
    run_txn(1'b0, 16'hC000, 16'h0000, 2'b00, 0, 1'b0, 16'h3333, 1'b0);  // decode error
    run_txn(1'b1, 16'h4044, 16'h9999, 2'b01, 10, 1'b0, 16'h0000, 1'b1); // reset mid-ACCESS
    run_txn(1'b0, 16'h8010, 16'h0000, 2'b00, 2, 1'b0, 16'hC0DE, 1'b0);  // normal after reset

    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom);
      run_txn(1'($urandom), a, DW'($urandom), STW'($urandom), int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0), DW'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge pclk);
    end

    repeat (20) @(negedge pclk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_rsp got %0d responses outstanding, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
